// File: rtl/reg_xfer_seq_if.sv
// Transfer-request and register-strobe bundle between the instruction decoder,
// the reg_xfer_seq sequencer and the 8-bit register bank.
//
// Handshake: a transfer is accepted at a rising clk edge where req_i=1 and
// ready_o=1; src_i/dst_i are sampled only at that edge. req_i, src_i and dst_i
// are ignored whenever ready_o=0. Completion is a one-cycle done_o pulse;
// rejection (bad index) is a one-cycle err_o pulse.
interface reg_xfer_seq_if #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
);
  logic                req_i;
  logic [IDX_W-1:0]    src_i;
  logic [IDX_W-1:0]    dst_i;
  logic                ready_o;
  logic                done_o;
  logic                err_o;
  logic [NUM_REGS-1:0] ff_rd_o;
  logic [NUM_REGS-1:0] ff_wr_o;
  logic [1:0]          state_o;

  modport master (
    output req_i, src_i, dst_i,
    input  ready_o, done_o, err_o, ff_rd_o, ff_wr_o, state_o
  );

  modport slave (
    input  req_i, src_i, dst_i,
    output ready_o, done_o, err_o, ff_rd_o, ff_wr_o, state_o
  );
endinterface

// File: rtl/reg_xfer_seq.sv
// Register-to-register transfer sequencer. Drives the register bank's one-hot
// ff_rd/ff_wr strobes so that exactly one source drives the internal bus for
// SETTLE_CYC cycles before the destination write strobe fires for one cycle.
// Optional transfer counter output xfer_cnt_o is built when the macro
// REG_XFER_SEQ_CNT_EN is defined.
module reg_xfer_seq #(
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic          clk50M_i,
  input  logic          rst_i,
  reg_xfer_seq_if.slave bus
`ifdef REG_XFER_SEQ_CNT_EN
  ,
  output logic [15:0]   xfer_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]     CNT_LOAD = 4'(SETTLE_CYC - 1);
  // One extra bit so the range check is meaningful when NUM_REGS == 2**IDX_W.
  localparam logic [IDX_W:0] NUM_W    = (IDX_W + 1)'(NUM_REGS);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [IDX_W-1:0]    dst_q, dst_d;
  logic                bad_q, bad_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                accept;
  logic                idx_bad;
  logic                ready_d, done_d, err_d;
  logic [NUM_REGS-1:0] rd_d, wr_d;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign accept  = bus.req_i && bus.ready_o;
  assign idx_bad = ({1'b0, bus.src_i} >= NUM_W) || ({1'b0, bus.dst_i} >= NUM_W);
  assign bus.state_o = state_q;

  // State and captured-transfer registers.
  always_ff @(posedge clk50M_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      bad_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the request is captured only on the accept edge.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d = bus.src_i;
          dst_d = bus.dst_i;
          bad_d = idx_bad;
          cnt_d = CNT_LOAD;
          // Bad index and src==dst both skip the bus entirely.
          if (idx_bad || (bus.src_i == bus.dst_i)) state_d = DONE;
          else                                     state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = WRITE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output can be a flop.
  always_comb begin
    ready_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = '0;
    wr_d    = '0;
    case (state_d)
      IDLE:   ready_d = 1'b1;
      SETTLE: rd_d    = onehot(src_d);
      WRITE: begin
        rd_d = onehot(src_d);
        wr_d = onehot(dst_d);
      end
      DONE: begin
        done_d = !bad_d;
        err_d  = bad_d;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // Registered outputs; asynchronous reset drops all strobes immediately.
  always_ff @(posedge clk50M_i or posedge rst_i) begin
    if (rst_i) begin
      bus.ready_o <= 1'b1;
      bus.done_o  <= 1'b0;
      bus.err_o   <= 1'b0;
      bus.ff_rd_o <= '0;
      bus.ff_wr_o <= '0;
    end else begin
      bus.ready_o <= ready_d;
      bus.done_o  <= done_d;
      bus.err_o   <= err_d;
      bus.ff_rd_o <= rd_d;
      bus.ff_wr_o <= wr_d;
    end
  end

`ifdef REG_XFER_SEQ_CNT_EN
  // Saturating count of completed transfers, including src==dst no-ops.
  always_ff @(posedge clk50M_i or posedge rst_i) begin
    if (rst_i)                                   xfer_cnt_o <= 16'd0;
    else if (done_d && (xfer_cnt_o != 16'hFFFF)) xfer_cnt_o <= xfer_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Directed bench for reg_xfer_seq: three instances (default, SETTLE_CYC=3,
// NUM_REGS=6) sharing clock and reset, plus a behavioural register bank on the
// default instance so data movement can be observed.
module tb_reg_xfer_seq;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  reg_xfer_seq_if #(.NUM_REGS(8), .IDX_W(3)) if0 ();
  reg_xfer_seq_if #(.NUM_REGS(8), .IDX_W(3)) if1 ();
  reg_xfer_seq_if #(.NUM_REGS(6), .IDX_W(3)) if2 ();

`ifdef REG_XFER_SEQ_CNT_EN
  logic [15:0] cnt0, cnt1, cnt2;
`endif

  reg_xfer_seq #(.NUM_REGS(8), .IDX_W(3), .SETTLE_CYC(1)) u0 (
    .clk50M_i(clk), .rst_i(rst), .bus(if0.slave)
`ifdef REG_XFER_SEQ_CNT_EN
    , .xfer_cnt_o(cnt0)
`endif
  );
  reg_xfer_seq #(.NUM_REGS(8), .IDX_W(3), .SETTLE_CYC(3)) u1 (
    .clk50M_i(clk), .rst_i(rst), .bus(if1.slave)
`ifdef REG_XFER_SEQ_CNT_EN
    , .xfer_cnt_o(cnt1)
`endif
  );
  reg_xfer_seq #(.NUM_REGS(6), .IDX_W(3), .SETTLE_CYC(1)) u2 (
    .clk50M_i(clk), .rst_i(rst), .bus(if2.slave)
`ifdef REG_XFER_SEQ_CNT_EN
    , .xfer_cnt_o(cnt2)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register bank model for u0
  logic [7:0] regs0 [8];
  logic [7:0] bus0;
  logic       pre_en;
  logic [2:0] pre_idx;
  logic [7:0] pre_val;

  always_comb begin
    bus0 = 8'h00;
    for (int i = 0; i < 8; i++) if (if0.ff_rd_o[i]) bus0 = bus0 | regs0[i];
  end

  always @(posedge clk) begin
    if (pre_en) regs0[pre_idx] <= pre_val;
    for (int i = 0; i < 8; i++) if (if0.ff_wr_o[i]) regs0[i] <= bus0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // invariants on the 8-register instances, sampled on the falling edge
  always @(negedge clk) begin
    check("inv0", {28'd0, $onehot0(if0.ff_rd_o), $onehot0(if0.ff_wr_o),
                   (if0.ff_wr_o == 8'd0) || (if0.ff_rd_o != 8'd0),
                   !(if0.done_o && if0.err_o)}, 32'hF);
    check("inv1", {28'd0, $onehot0(if1.ff_rd_o), $onehot0(if1.ff_wr_o),
                   (if1.ff_wr_o == 8'd0) || (if1.ff_rd_o != 8'd0),
                   !(if1.done_o && if1.err_o)}, 32'hF);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [7:0] val);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    tick();
    pre_en  = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    pre_en = 1'b0; pre_idx = 3'd0; pre_val = 8'h00;
    if0.req_i = 1'b0; if0.src_i = 3'd0; if0.dst_i = 3'd0;
    if1.req_i = 1'b0; if1.src_i = 3'd0; if1.dst_i = 3'd0;
    if2.req_i = 1'b0; if2.src_i = 3'd0; if2.dst_i = 3'd0;
    tick();
    tick();

    // reset state
    check("rst_ready", if0.ready_o, 1);
    check("rst_dn_err", {if0.done_o, if0.err_o}, 0);
    check("rst_strobes", {if0.ff_rd_o, if0.ff_wr_o}, 0);
    check("rst_state", if0.state_o, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_quiet", {if0.ready_o, if0.done_o, if0.err_o, if0.ff_rd_o, if0.ff_wr_o},
            {1'b1, 18'd0});
    end

    // A(7)=5A -> B(0), SETTLE_CYC=1
    preload(3'd7, 8'h5A);
    preload(3'd0, 8'h00);
    if0.src_i = 3'd7; if0.dst_i = 3'd0; if0.req_i = 1'b1;
    tick();
    if0.req_i = 1'b0;
    check("a2b_c1_rd", if0.ff_rd_o, 8'h80);
    check("a2b_c1_wr", if0.ff_wr_o, 8'h00);
    check("a2b_c1_ready", if0.ready_o, 0);
    tick();
    check("a2b_c2_rd", if0.ff_rd_o, 8'h80);
    check("a2b_c2_wr", if0.ff_wr_o, 8'h01);
    check("a2b_c2_done", if0.done_o, 0);
    tick();
    check("a2b_c3_done", if0.done_o, 1);
    check("a2b_c3_strobes", {if0.ff_rd_o, if0.ff_wr_o}, 0);
    check("a2b_b_val", regs0[0], 8'h5A);
    tick();
    check("a2b_ready", if0.ready_o, 1);
    check("a2b_done_drop", if0.done_o, 0);

    // SETTLE_CYC=3, src=2 dst=5
    if1.src_i = 3'd2; if1.dst_i = 3'd5; if1.req_i = 1'b1;
    tick();
    if1.req_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("s3_settle_rd", if1.ff_rd_o, 8'h04);
      check("s3_settle_wr", if1.ff_wr_o, 8'h00);
      check("s3_settle_done", if1.done_o, 0);
      tick();
    end
    check("s3_write_rd", if1.ff_rd_o, 8'h04);
    check("s3_write_wr", if1.ff_wr_o, 8'h20);
    tick();
    check("s3_done", if1.done_o, 1);
    check("s3_done_strobes", {if1.ff_rd_o, if1.ff_wr_o}, 0);
    tick();
    check("s3_ready", if1.ready_o, 1);

    // NUM_REGS=6, bad source index
    if2.src_i = 3'd6; if2.dst_i = 3'd1; if2.req_i = 1'b1;
    tick();
    if2.req_i = 1'b0;
    check("bad_src_err", if2.err_o, 1);
    check("bad_src_done", if2.done_o, 0);
    check("bad_src_strobes", {if2.ff_rd_o, if2.ff_wr_o}, 0);
    check("bad_src_ready", if2.ready_o, 0);
    tick();
    check("bad_src_err_drop", if2.err_o, 0);
    check("bad_src_ready2", if2.ready_o, 1);

    // NUM_REGS=6, bad destination index
    if2.src_i = 3'd1; if2.dst_i = 3'd7; if2.req_i = 1'b1;
    tick();
    if2.req_i = 1'b0;
    check("bad_dst_err", {if2.err_o, if2.done_o, if2.ff_rd_o, if2.ff_wr_o}, {1'b1, 13'd0});
    tick();
`ifdef REG_XFER_SEQ_CNT_EN
    check("cnt_after_err", cnt2, 16'd0);
`endif

    // src==dst no-op
    if2.src_i = 3'd3; if2.dst_i = 3'd3; if2.req_i = 1'b1;
    tick();
    if2.req_i = 1'b0;
    check("noop_done", if2.done_o, 1);
    check("noop_err", if2.err_o, 0);
    check("noop_strobes", {if2.ff_rd_o, if2.ff_wr_o}, 0);
`ifdef REG_XFER_SEQ_CNT_EN
    check("noop_cnt", cnt2, 16'd1);
`endif
    tick();
    check("noop_ready", if2.ready_o, 1);

    // reset during SETTLE on u0: src=4 (C3) dst=1 (11)
    preload(3'd4, 8'hC3);
    preload(3'd1, 8'h11);
    if0.src_i = 3'd4; if0.dst_i = 3'd1; if0.req_i = 1'b1;
    tick();
    if0.req_i = 1'b0;
    check("mid_settle_rd", if0.ff_rd_o, 8'h10);
    rst = 1'b1;
    #2;
    check("mid_settle_async_strobes", {if0.ff_rd_o, if0.ff_wr_o}, 0);
    check("mid_settle_async_ready", if0.ready_o, 1);
    tick();
    tick();
    check("mid_settle_no_done", if0.done_o, 0);
    check("mid_settle_dst_kept", regs0[1], 8'h11);
    rst = 1'b0;
    tick();
    check("mid_settle_ready", if0.ready_o, 1);
    check("mid_settle_state", if0.state_o, 0);
    check("mid_settle_dst_still", regs0[1], 8'h11);
    if0.req_i = 1'b1;
    tick();
    if0.req_i = 1'b0;
    tick();
    tick();
    check("retry_done", if0.done_o, 1);
    check("retry_dst_val", regs0[1], 8'hC3);
    tick();

    // reset during WRITE on u1: src=0 dst=1
    if1.src_i = 3'd0; if1.dst_i = 3'd1; if1.req_i = 1'b1;
    tick();
    if1.req_i = 1'b0;
    tick();
    tick();
    tick();
    check("mid_write_wr", if1.ff_wr_o, 8'h02);
    rst = 1'b1;
    #2;
    check("mid_write_async_strobes", {if1.ff_rd_o, if1.ff_wr_o}, 0);
    tick();
    check("mid_write_no_done", if1.done_o, 0);
    rst = 1'b0;
    tick();
    check("mid_write_ready", if1.ready_o, 1);
`ifdef REG_XFER_SEQ_CNT_EN
    check("cnt_reset", cnt1, 16'd0);
`endif

    // back-to-back on u1 after reset: new transfer completes normally
    if1.src_i = 3'd6; if1.dst_i = 3'd7; if1.req_i = 1'b1;
    tick();
    if1.req_i = 1'b0;
    tick();
    tick();
    tick();
    check("post_rst_wr", {if1.ff_rd_o, if1.ff_wr_o}, {8'h40, 8'h80});
    tick();
    check("post_rst_done", if1.done_o, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
